gpio_peripheral: RTL and testbench

GPIO_PERIPHERAL -- requirements
Module: gpio_peripheral

---
 rtl/gpio_peripheral.sv | 80 ++++++++
 tb/tb_gpio_peripheral.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_peripheral.sv
// rtl/gpio_peripheral.sv - 16-bit GPIO port with CPU-bus register access
module gpio_peripheral #(
    parameter logic [7:0] ADDR_IN  = 8'h04,
    parameter logic [7:0] ADDR_OUT = 8'h05,
    parameter logic [7:0] ADDR_DIR = 8'h06
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Read_In,
    input  logic        Load_Out,
    input  logic        Load_DIR,
    input  logic [7:0]  addressbus,
    inout  wire  [15:0] databus,
    inout  wire  [15:0] inout_bus,
    output logic [15:0] R_IN,
    output logic [15:0] R_OUT,
    output logic [15:0] R_DIR,
    output logic        IN_TEST,
    output logic        OUT_TEST
);

    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [15:0] r_dir;

    logic        w_wr_out;
    logic        w_wr_dir;
    logic        w_rd_en;
    logic [15:0] w_rd_data;

    assign w_wr_out = Load_Out && (addressbus == ADDR_OUT);
    assign w_wr_dir = Load_DIR && (addressbus == ADDR_DIR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in  <= 16'h0000;
            r_out <= 16'h0000;
            r_dir <= 16'h0000;
        end else begin
            r_in <= inout_bus;
            if (w_wr_out) begin
                r_out <= databus;
            end
            if (w_wr_dir) begin
                r_dir <= databus;
            end
        end
    end

    // Any load strobe blocks the read drive so the block never fights the bus master.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_data = 16'h0000;
        if (Read_In && !Load_Out && !Load_DIR) begin
            if (addressbus == ADDR_IN) begin
                w_rd_en   = 1'b1;
                w_rd_data = r_in;
            end else if (addressbus == ADDR_OUT) begin
                w_rd_en   = 1'b1;
                w_rd_data = r_out;
            end else if (addressbus == ADDR_DIR) begin
                w_rd_en   = 1'b1;
                w_rd_data = r_dir;
            end
        end
    end

    assign databus = w_rd_en ? w_rd_data : 16'bz;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pin
        assign inout_bus[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
    end

    assign R_IN     = r_in;
    assign R_OUT    = r_out;
    assign R_DIR    = r_dir;
    assign IN_TEST  = w_rd_en;
    assign OUT_TEST = |r_dir;

endmodule

// File: tb/tb_gpio_peripheral.sv
// tb/tb_gpio_peripheral.sv - scoreboard bench for gpio_peripheral
module tb_gpio_peripheral;

    logic        clk = 1'b0;
    logic        reset;
    logic        Read_In;
    logic        Load_Out;
    logic        Load_DIR;
    logic [7:0]  addressbus;
    wire  [15:0] databus;
    wire  [15:0] inout_bus;
    logic [15:0] R_IN;
    logic [15:0] R_OUT;
    logic [15:0] R_DIR;
    logic        IN_TEST;
    logic        OUT_TEST;

    logic [15:0] tb_data;
    logic        tb_data_en;
    logic [15:0] tb_pin;
    logic [15:0] tb_pin_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];

    localparam int S_RIN  = 0;
    localparam int S_ROUT = 1;
    localparam int S_RDIR = 2;
    localparam int S_DBUS = 3;
    localparam int S_PINS = 4;
    localparam int S_INT  = 5;
    localparam int S_OUTT = 6;

    assign databus = tb_data_en ? tb_data : 16'bz;
    for (genvar gi = 0; gi < 16; gi++) begin : g_tb_pin
        assign inout_bus[gi] = tb_pin_en[gi] ? tb_pin[gi] : 1'bz;
    end

    gpio_peripheral dut (
        .clk        (clk),
        .reset      (reset),
        .Read_In    (Read_In),
        .Load_Out   (Load_Out),
        .Load_DIR   (Load_DIR),
        .addressbus (addressbus),
        .databus    (databus),
        .inout_bus  (inout_bus),
        .R_IN       (R_IN),
        .R_OUT      (R_OUT),
        .R_DIR      (R_DIR),
        .IN_TEST    (IN_TEST),
        .OUT_TEST   (OUT_TEST)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pick(input int sel);
        case (sel)
            S_RIN:   return R_IN;
            S_ROUT:  return R_OUT;
            S_RDIR:  return R_DIR;
            S_DBUS:  return databus;
            S_PINS:  return inout_bus;
            S_INT:   return {15'd0, IN_TEST};
            default: return {15'd0, OUT_TEST};
        endcase
    endfunction

    // Monitor: compares every queued expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [15:0] act;
                e   = sb_q.pop_front();
                act = pick(e.sel);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(posedge clk or negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Read_In    = 1'b0;
        Load_Out   = 1'b0;
        Load_DIR   = 1'b0;
        tb_data_en = 1'b0;
    endtask

    task automatic bus_write(input logic ld_out, input logic ld_dir,
                             input logic [7:0] addr, input logic [15:0] data);
        Load_Out   = ld_out;
        Load_DIR   = ld_dir;
        addressbus = addr;
        tb_data    = data;
        tb_data_en = 1'b1;
        step();
        idle();
    endtask

    initial begin
        reset      = 1'b1;
        tb_data    = 16'h0000;
        tb_pin     = 16'h5A5A;
        tb_pin_en  = 16'hFFFF;
        addressbus = 8'h00;
        idle();
        step();
        step();

        expect_val("reset_rin",   S_RIN,  16'h0000);
        expect_val("reset_rout",  S_ROUT, 16'h0000);
        expect_val("reset_rdir",  S_RDIR, 16'h0000);
        expect_val("reset_intst", S_INT,  16'h0000);
        expect_val("reset_outt",  S_OUTT, 16'h0000);
        expect_val("reset_pins_undriven", S_PINS, 16'h5A5A);
        drain();

        bus_write(1'b0, 1'b1, 8'h06, 16'hFFFF);
        expect_val("reset_write_ignored", S_RDIR, 16'h0000);
        Read_In    = 1'b1;
        addressbus = 8'h05;
        expect_val("reset_read_data",  S_DBUS, 16'h0000);
        expect_val("reset_read_intst", S_INT,  16'h0001);
        drain();
        idle();
        tb_pin_en = 16'h0000;
        reset     = 1'b0;
        step();

        bus_write(1'b0, 1'b1, 8'h06, 16'hFFFF);
        expect_val("dir_write_rdir", S_RDIR, 16'hFFFF);
        expect_val("dir_write_outt", S_OUTT, 16'h0001);
        expect_val("dir_write_pins", S_PINS, 16'h0000);
        drain();

        bus_write(1'b1, 1'b0, 8'h05, 16'h0008);
        expect_val("out_write_rout", S_ROUT, 16'h0008);
        expect_val("out_write_pins", S_PINS, 16'h0008);
        expect_val("out_write_rin_lag", S_RIN, 16'h0000);
        drain();
        step();
        expect_val("out_write_rin", S_RIN, 16'h0008);
        Read_In    = 1'b1;
        addressbus = 8'h05;
        expect_val("read_rout", S_DBUS, 16'h0008);
        drain();
        idle();

        bus_write(1'b0, 1'b1, 8'h06, 16'h0000);
        tb_pin    = 16'h0003;
        tb_pin_en = 16'hFFFF;
        step();
        Read_In    = 1'b1;
        addressbus = 8'h04;
        expect_val("in_read_dbus",  S_DBUS, 16'h0003);
        expect_val("in_read_rin",   S_RIN,  16'h0003);
        expect_val("in_read_intst", S_INT,  16'h0001);
        expect_val("in_read_outt",  S_OUTT, 16'h0000);
        drain();
        idle();

        tb_pin    = 16'h3C00;
        tb_pin_en = 16'hFF00;
        bus_write(1'b0, 1'b1, 8'h06, 16'h00FF);
        bus_write(1'b1, 1'b0, 8'h05, 16'h00A5);
        step();
        expect_val("mixed_pins", S_PINS, 16'h3CA5);
        expect_val("mixed_rin",  S_RIN,  16'h3CA5);
        Read_In    = 1'b1;
        addressbus = 8'h06;
        expect_val("read_rdir", S_DBUS, 16'h00FF);
        drain();
        idle();

        Read_In    = 1'b1;
        Load_DIR   = 1'b1;
        addressbus = 8'h06;
        tb_data    = 16'h1234;
        tb_data_en = 1'b1;
        expect_val("conflict_intst", S_INT,  16'h0000);
        expect_val("conflict_dbus",  S_DBUS, 16'h1234);
        drain();
        step();
        idle();
        expect_val("conflict_rdir", S_RDIR, 16'h1234);
        drain();

        bus_write(1'b1, 1'b0, 8'h07, 16'hFFFF);
        expect_val("bad_addr_rout", S_ROUT, 16'h00A5);
        Read_In    = 1'b1;
        addressbus = 8'h07;
        expect_val("bad_addr_read_intst", S_INT, 16'h0000);
        drain();
        idle();

        bus_write(1'b1, 1'b1, 8'h05, 16'h0F0F);
        expect_val("dual_strobe_rout", S_ROUT, 16'h0F0F);
        expect_val("dual_strobe_rdir", S_RDIR, 16'h1234);
        drain();

        Load_Out   = 1'b1;
        addressbus = 8'h05;
        tb_data    = 16'hBEEF;
        tb_data_en = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        expect_val("async_reset_rout", S_ROUT, 16'h0000);
        expect_val("async_reset_rdir", S_RDIR, 16'h0000);
        expect_val("async_reset_outt", S_OUTT, 16'h0000);
        drain();
        step();
        expect_val("reset_mid_write_lost", S_ROUT, 16'h0000);
        drain();
        idle();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
